sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Sequences the external asynchronous SRAM and shares it between two bus masters: port 0 (Z80 CPU) and port 1 (DMA/loader).
- Generates the SRAM control strobes with a programmable number of wait states, with address setup and write-data hold.
- Returns a one-cycle acknowledge, plus read data, to the granted master.
- Sits between the z80computer core and the top-level SRAM pins. The top-level tristates the data bus from o_sram_dat_oe.

Parameters:
- ADDR_W, 16, address width of both ports and the SRAM.
- DATA_W, 8, data width.
- WAIT_STATES, 1, extra strobe cycles beyond one (legal range 0..15). The strobe is low for WAIT_STATES+1 cycles.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset_n  in  1  synchronous reset, active-low.
- i_p0_cs  in  1  port 0 request; level, held until o_p0_ack.
- i_p0_we  in  1  port 0 write (1) / read (0).
- i_p0_addr  in  ADDR_W  port 0 address.
- i_p0_dat  in  DATA_W  port 0 write data.
- o_p0_dat  out  DATA_W  port 0 read data.
- o_p0_ack  out  1  port 0 transfer done, one-cycle pulse.
- i_p1_cs, i_p1_we, i_p1_addr, i_p1_dat, o_p1_dat, o_p1_ack: same as port 0, for port 1.
- o_sram_addr  out  ADDR_W  SRAM address.
- o_sram_dat  out  DATA_W  SRAM write data.
- i_sram_dat  in  DATA_W  SRAM read data.
- o_sram_dat_oe  out  1  1 = controller drives the data bus.
- o_sram_cs_n  out  1  SRAM chip select, active-low.
- o_sram_oe_n  out  1  SRAM output enable, active-low.
- o_sram_we_n  out  1  SRAM write enable, active-low.
- o_busy  out  1  1 while any state other than IDLE.

Behaviour:
- Reset (i_reset_n low at an edge, from any state, including mid-access): at that edge all outputs take their reset values.
  - State = IDLE.
  - o_sram_cs_n, o_sram_oe_n, o_sram_we_n = 1.
  - o_sram_dat_oe = 0.
  - o_sram_addr, o_sram_dat, o_p0_dat, o_p1_dat = 0.
  - o_p0_ack, o_p1_ack, o_busy = 0.
  - Last-served pointer = port 1.
  - No ack is ever issued for an aborted access.
- All outputs are registered.
- States: IDLE -> SETUP -> ACCESS -> HOLD -> ACK -> IDLE.
- IDLE:
  - If any i_pN_cs is high, arbitrate and latch the winner's addr, we and dat, plus the grant index, into o_sram_addr/o_sram_dat; go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (1 cycle):
  - cs_n = 0, strobes high.
  - o_sram_dat_oe = 1 for a write.
  - Load wait counter = WAIT_STATES.
- ACCESS (WAIT_STATES+1 cycles):
  - cs_n = 0.
  - Read: oe_n = 0. Write: we_n = 0, dat_oe = 1.
  - Counter decrements each cycle; leave ACCESS when it is 0.
  - Read: at the edge leaving ACCESS, capture i_sram_dat into o_pN_dat of the granted port.
- HOLD (1 cycle):
  - oe_n = we_n = 1, cs_n = 0.
  - Write data stays driven (dat_oe = 1) for data hold; address unchanged.
- ACK (1 cycle):
  - cs_n = 1, dat_oe = 0.
  - o_pN_ack = 1 for the granted port only.
  - Update last-served pointer = granted port.
- Latency, from the IDLE cycle where the request is seen to the ack cycle: WAIT_STATES+4 cycles (5 with default).
- Requester rules:
  - The requester samples ack at the edge and changes i_pN_cs on that edge.
  - The IDLE cycle after ACK evaluates the updated requests, so back-to-back transfers are allowed: one IDLE cycle between accesses.
- Request inputs are ignored outside IDLE; a request dropped mid-access still completes and acks.
- o_pN_dat holds its value except on a read completion for that port; a write never alters it.
- The address wraps naturally at 2^ADDR_W (no checks).
- Grant never changes outside IDLE.
- Write data and address stay stable from SETUP through HOLD.
- we_n and oe_n are never low simultaneously.

Optional Feature:
- SRAM_ARB_ROUND_ROBIN_EN defined:
  - Simultaneous requests are granted to the port not in the last-served pointer.
  - A single request is granted immediately.
- Not defined:
  - Fixed priority; port 0 always wins simultaneous requests.
  - The last-served pointer is still maintained but unused.

Test Plan:
- Port 0 write, addr 0x1234, dat 0xA5, WAIT_STATES=1:
  - cs_n low for 4 cycles; we_n low exactly 2 cycles; dat_oe high 4 cycles; o_p0_ack single pulse 5 cycles after request; o_p1_ack stays 0.
- Port 1 read, addr 0x00FF, SRAM model returns 0x5A:
  - oe_n low 2 cycles, we_n stays 1; o_p1_dat = 0x5A on the ack cycle; o_p0_dat unchanged.
- Both ports request continuously, reads:
  - With SRAM_ARB_ROUND_ROBIN_EN, grants alternate 0,1,0,1 and each access is separated by one IDLE cycle.
  - Without the macro, port 0 is granted every time and port 1 never acks.
- Reset low during ACCESS of a write:
  - Next edge: cs_n = we_n = oe_n = 1, dat_oe = 0, o_busy = 0, no ack.
  - After reset release, the first simultaneous request is granted to port 0.
- WAIT_STATES=0 then 15:
  - Strobe width 1 and 16 cycles, ack latency 4 and 19 cycles.
- Port 0 drops cs during SETUP:
  - The access still completes and o_p0_ack pulses once.
  - The arbiter then returns to IDLE with o_busy = 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between two bus masters.
//
// Port 0 (Z80 CPU) and port 1 (DMA/loader) issue level requests (i_pN_cs held
// until o_pN_ack). The winner's address, direction and write data are latched
// in IDLE. The access then runs SETUP -> ACCESS (WAIT_STATES+1 cycles) ->
// HOLD -> ACK. Address is set up one cycle before the strobe, and write data is
// held one cycle after it. All outputs are registered.
//
// Ports:
//   i_clk, i_reset_n           clock, synchronous active-low reset
//   i_pN_cs/we/addr/dat        master N request, direction, address, write data
//   o_pN_dat, o_pN_ack         master N read data, one-cycle done pulse
//   o_sram_addr/dat            SRAM address and write data
//   i_sram_dat                 SRAM read data
//   o_sram_dat_oe              1 = controller drives the SRAM data bus
//   o_sram_cs_n/oe_n/we_n      SRAM strobes, active-low
//   o_busy                     1 whenever the sequencer is not idle
//
// Build option: define SRAM_ARB_ROUND_ROBIN_EN to hand simultaneous requests to
// the port that was not served last. The default build uses fixed priority,
// where port 0 wins.
module sram_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_p0_cs,
  input  logic              i_p0_we,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic [DATA_W-1:0] i_p0_dat,
  output logic [DATA_W-1:0] o_p0_dat,
  output logic              o_p0_ack,
  input  logic              i_p1_cs,
  input  logic              i_p1_we,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic [DATA_W-1:0] i_p1_dat,
  output logic [DATA_W-1:0] o_p1_dat,
  output logic              o_p1_ack,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dat,
  input  logic [DATA_W-1:0] i_sram_dat,
  output logic              o_sram_dat_oe,
  output logic              o_sram_cs_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_busy
);

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StHold, StAck} state_e;

  state_e     state_q;
  logic [3:0] wait_q;
  logic       grant_q;  // 0 = port 0, 1 = port 1; frozen outside IDLE
  logic       we_q;
  logic       last_q;   // last-served port
  logic       grant;

  // The default value of grant only matters when nobody is requesting. It then
  // has no effect.
  always_comb begin
    grant = last_q;
    if (i_p0_cs && i_p1_cs) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      grant = ~last_q;
`else
      grant = 1'b0;
`endif
    end else if (i_p0_cs) begin
      grant = 1'b0;
    end else if (i_p1_cs) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= StIdle;
      wait_q        <= '0;
      grant_q       <= 1'b0;
      we_q          <= 1'b0;
      last_q        <= 1'b1;
      o_sram_cs_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
      o_sram_dat_oe <= 1'b0;
      o_sram_addr   <= '0;
      o_sram_dat    <= '0;
      o_p0_dat      <= '0;
      o_p1_dat      <= '0;
      o_p0_ack      <= 1'b0;
      o_p1_ack      <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_p0_cs || i_p1_cs) begin
            state_q       <= StSetup;
            o_busy        <= 1'b1;
            grant_q       <= grant;
            we_q          <= grant ? i_p1_we : i_p0_we;
            o_sram_addr   <= grant ? i_p1_addr : i_p0_addr;
            o_sram_dat    <= grant ? i_p1_dat : i_p0_dat;
            o_sram_cs_n   <= 1'b0;
            // Writes drive the bus from SETUP so the data settles before we_n falls.
            o_sram_dat_oe <= grant ? i_p1_we : i_p0_we;
          end
        end
        StSetup: begin
          state_q     <= StAccess;
          wait_q      <= WaitInit;
          o_sram_oe_n <= we_q;
          o_sram_we_n <= ~we_q;
        end
        StAccess: begin
          if (wait_q == 4'd0) begin
            state_q     <= StHold;
            o_sram_oe_n <= 1'b1;
            o_sram_we_n <= 1'b1;
            if (!we_q) begin
              if (grant_q) o_p1_dat <= i_sram_dat;
              else         o_p0_dat <= i_sram_dat;
            end
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StHold: begin
          state_q       <= StAck;
          o_sram_cs_n   <= 1'b1;
          o_sram_dat_oe <= 1'b0;
          o_p0_ack      <= ~grant_q;
          o_p1_ack      <= grant_q;
          last_q        <= grant_q;
        end
        StAck: begin
          state_q  <= StIdle;
          o_p0_ack <= 1'b0;
          o_p1_ack <= 1'b0;
          o_busy   <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int WS = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        p0_cs, p0_we, p1_cs, p1_we;
  logic [15:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdat, p1_wdat, p0_rdat, p1_rdat;
  logic        p0_ack, p1_ack;
  logic [15:0] sram_addr;
  logic [7:0]  sram_wdat, sram_rdat;
  logic        sram_dat_oe, sram_cs_n, sram_oe_n, sram_we_n, busy;

  sram_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(WS)) u_dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_p0_cs(p0_cs), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_dat(p0_wdat),
    .o_p0_dat(p0_rdat), .o_p0_ack(p0_ack),
    .i_p1_cs(p1_cs), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_dat(p1_wdat),
    .o_p1_dat(p1_rdat), .o_p1_ack(p1_ack),
    .o_sram_addr(sram_addr), .o_sram_dat(sram_wdat), .i_sram_dat(sram_rdat),
    .o_sram_dat_oe(sram_dat_oe), .o_sram_cs_n(sram_cs_n), .o_sram_oe_n(sram_oe_n),
    .o_sram_we_n(sram_we_n), .o_busy(busy)
  );

  // Asynchronous SRAM model
  logic [7:0] mem [0:65535];
  assign sram_rdat = sram_oe_n ? 8'h00 : mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_cs_n && !sram_we_n && sram_dat_oe) mem[sram_addr] <= sram_wdat;
  end

  // Extra instances for WAIT_STATES = 0 and 15 (port 0 reads only)
  logic       x_cs [2];
  logic       x_p0_ack [2], x_p1_ack [2], x_doe [2], x_cs_n [2], x_oe_n [2], x_we_n [2];
  logic       x_busy [2];
  logic [7:0] x_p0_dat [2], x_p1_dat [2], x_sdat [2];
  logic [15:0] x_saddr [2];
  for (genvar k = 0; k < 2; k++) begin : g_ws
    sram_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES((k == 0) ? 0 : 15)) u_dut (
      .i_clk(clk), .i_reset_n(reset_n),
      .i_p0_cs(x_cs[k]), .i_p0_we(1'b0), .i_p0_addr(16'h0010), .i_p0_dat(8'h00),
      .o_p0_dat(x_p0_dat[k]), .o_p0_ack(x_p0_ack[k]),
      .i_p1_cs(1'b0), .i_p1_we(1'b0), .i_p1_addr(16'h0000), .i_p1_dat(8'h00),
      .o_p1_dat(x_p1_dat[k]), .o_p1_ack(x_p1_ack[k]),
      .o_sram_addr(x_saddr[k]), .o_sram_dat(x_sdat[k]), .i_sram_dat(8'h3C),
      .o_sram_dat_oe(x_doe[k]), .o_sram_cs_n(x_cs_n[k]), .o_sram_oe_n(x_oe_n[k]),
      .o_sram_we_n(x_we_n[k]), .o_busy(x_busy[k])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: stimulus pushes expectations, monitor pops on every ack.
  typedef struct packed {
    logic       port;
    logic       we;
    logic [7:0] rdat;
  } exp_t;
  exp_t sb_q[$];

  int         n_busy, n_cs, n_oe, n_we, n_doe;
  bit         overlap;
  logic [7:0] mdl_dat [2];

  always @(negedge clk) begin
    if (!reset_n) begin
      n_busy = 0; n_cs = 0; n_oe = 0; n_we = 0; n_doe = 0; overlap = 0;
      mdl_dat[0] = 8'h00; mdl_dat[1] = 8'h00;
    end else begin
      if (busy) n_busy++;
      if (!sram_cs_n) n_cs++;
      if (!sram_oe_n) n_oe++;
      if (!sram_we_n) n_we++;
      if (sram_dat_oe) n_doe++;
      if (!sram_oe_n && !sram_we_n) overlap = 1;
      if (p0_ack || p1_ack) begin
        check("ack_pending", 32'(sb_q.size() > 0), 1);
        check("dual_ack", 32'(p0_ack & p1_ack), 0);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("ack_port", 32'(p1_ack), 32'(e.port));
          if (!e.we) mdl_dat[e.port] = e.rdat;
          check("p0_dat", 32'(p0_rdat), 32'(mdl_dat[0]));
          check("p1_dat", 32'(p1_rdat), 32'(mdl_dat[1]));
          check("latency", n_busy, WS + 4);
          check("cs_width", n_cs, WS + 3);
          check("strobe_width", e.we ? n_we : n_oe, WS + 1);
          check("idle_strobe", e.we ? n_oe : n_we, 0);
          check("dat_oe_width", n_doe, e.we ? WS + 3 : 0);
          check("strobe_overlap", 32'(overlap), 0);
        end
        n_busy = 0; n_cs = 0; n_oe = 0; n_we = 0; n_doe = 0; overlap = 0;
      end
    end
  end

  task automatic xfer(input bit port, input bit we, input logic [15:0] addr,
                      input logic [7:0] wdat, input logic [7:0] rdat, input bit drop_early);
    exp_t e;
    logic a;
    e.port = port; e.we = we; e.rdat = rdat;
    sb_q.push_back(e);
    @(negedge clk);
    if (port) begin p1_cs = 1; p1_we = we; p1_addr = addr; p1_wdat = wdat; end
    else      begin p0_cs = 1; p0_we = we; p0_addr = addr; p0_wdat = wdat; end
    a = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      // First negedge after the request is the SETUP cycle.
      if (i == 0 && drop_early) begin
        if (port) p1_cs = 0; else p0_cs = 0;
      end
      a = port ? p1_ack : p0_ack;
      if (a) break;
    end
    check("ack_seen", 32'(a), 1);
    if (port) p1_cs = 0; else p0_cs = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h00FF] = 8'h5A;
    reset_n = 0;
    p0_cs = 0; p0_we = 0; p0_addr = '0; p0_wdat = '0;
    p1_cs = 0; p1_we = 0; p1_addr = '0; p1_wdat = '0;
    x_cs[0] = 0; x_cs[1] = 0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_strobes", {29'd0, sram_cs_n, sram_oe_n, sram_we_n}, 3'b111);
    check("rst_dat_oe", 32'(sram_dat_oe), 0);
    check("rst_addr", 32'(sram_addr), 0);
    check("rst_wdat", 32'(sram_wdat), 0);
    check("rst_rdat", {16'd0, p0_rdat, p1_rdat}, 0);
    check("rst_ack_busy", {29'd0, p0_ack, p1_ack, busy}, 0);
    reset_n = 1;

    // Directed transfers
    xfer(0, 1, 16'h1234, 8'hA5, 8'h00, 0);
    xfer(1, 0, 16'h00FF, 8'h00, 8'h5A, 0);
    xfer(0, 0, 16'h1234, 8'h00, 8'hA5, 0);
    xfer(1, 1, 16'h0042, 8'h3C, 8'h00, 0);
    xfer(0, 0, 16'h0042, 8'h00, 8'h3C, 0);
    xfer(1, 0, 16'hFFFF, 8'h00, 8'h00, 0);

    // Request dropped during SETUP still completes once
    xfer(0, 0, 16'h00FF, 8'h00, 8'h5A, 1);
    @(negedge clk);
    check("idle_after_drop", 32'(busy), 0);
    repeat (3) @(negedge clk);

    // Reset during ACCESS of a write
    p0_cs = 1; p0_we = 1; p0_addr = 16'h2000; p0_wdat = 8'h77;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_we_n) break;
    end
    check("abort_in_access", 32'(sram_we_n), 0);
    reset_n = 0;
    p0_cs = 0;
    @(negedge clk);
    check("abort_strobes", {29'd0, sram_cs_n, sram_oe_n, sram_we_n}, 3'b111);
    check("abort_dat_oe", 32'(sram_dat_oe), 0);
    check("abort_ack_busy", {29'd0, p0_ack, p1_ack, busy}, 0);
    check("abort_rdat", {16'd0, p0_rdat, p1_rdat}, 0);
    @(negedge clk);
    reset_n = 1;

    // Both ports request reads continuously
    begin
      bit exp_port [4];
      int acks;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_port = '{0, 1, 0, 1};
`else
      exp_port = '{0, 0, 0, 0};
`endif
      for (int i = 0; i < 4; i++) begin
        exp_t e;
        e.port = exp_port[i]; e.we = 0; e.rdat = exp_port[i] ? 8'h5A : 8'hA5;
        sb_q.push_back(e);
      end
      @(negedge clk);
      p0_cs = 1; p0_we = 0; p0_addr = 16'h1234;
      p1_cs = 1; p1_we = 0; p1_addr = 16'h00FF;
      acks = 0;
      while (acks < 4) begin
        logic a;
        a = 0;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          a = p0_ack | p1_ack;
          if (a) break;
        end
        check("both_ack_seen", 32'(a), 1);
        if (!a) break;
        acks++;
        if (acks == 4) begin
          p0_cs = 0; p1_cs = 0;
        end else begin
          @(negedge clk);
          check("gap_idle", 32'(busy), 0);
          @(negedge clk);
          check("gap_restart", 32'(busy), 1);
        end
      end
      p0_cs = 0; p1_cs = 0;
    end
    repeat (4) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    // Wait-state extremes: strobe width and ack latency
    for (int k = 0; k < 2; k++) begin
      int lat, w;
      logic a;
      lat = 0; w = 0; a = 0;
      @(negedge clk);
      x_cs[k] = 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        lat++;
        if (!x_oe_n[k]) w++;
        a = x_p0_ack[k];
        if (a) break;
      end
      x_cs[k] = 0;
      check("ws_ack_seen", 32'(a), 1);
      check("ws_latency", lat, (k == 0) ? 4 : 19);
      check("ws_strobe", w, (k == 0) ? 1 : 16);
      check("ws_rdat", 32'(x_p0_dat[k]), 32'h3C);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
